// File: rtl/msi_bus_request_sequencer.sv
// MSI bus request sequencer: issues write-back/miss/invalidate bus work, then commits.
// Optional MSI_BUS_TIMEOUT_EN: abandon a bus wait after TIMEOUT_CYCLES without bus_ack.
module msi_bus_request_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  input  logic                  cpu_req_write,
  input  logic                  cpu_hit,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [ADDR_WIDTH-1:0] victim_addr,
  input  logic [1:0]            state_current,
  input  logic [1:0]            state_next,
  input  logic                  bus_grant,
  input  logic                  bus_ack,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic                  bus_req,
  output logic [1:0]            bus_cmd,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  state_we,
  output logic [1:0]            state_wdata,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_WB_WAIT, S_REQ, S_WAIT, S_COMMIT
  } fsm_t;

  localparam logic [1:0] ST_M   = 2'b01;
  localparam logic [1:0] ST_S   = 2'b10;
  localparam logic [1:0] ST_ERR = 2'b11;

  localparam logic [1:0] CMD_INV = 2'b00;
  localparam logic [1:0] CMD_WM  = 2'b01;
  localparam logic [1:0] CMD_RM  = 2'b10;
  localparam logic [1:0] CMD_WB  = 2'b11;

  fsm_t                  state_q, state_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] caddr_q, caddr_d;
  logic                  write_q, write_d;
  logic [1:0]            snext_q, snext_d;
  logic                  error_q, error_d;

`ifdef MSI_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    caddr_d = caddr_q;
    write_d = write_q;
    snext_d = snext_q;
    error_d = error_q;
`ifdef MSI_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cpu_req_valid) begin
          write_d = cpu_req_write;
          caddr_d = cpu_addr;
          snext_d = state_next;
          if (state_next == ST_ERR || state_current == ST_ERR) begin
            error_d = 1'b1;
          end else if (cpu_hit &&
                       (!cpu_req_write || state_current == ST_M)) begin
            state_d = S_COMMIT;
          end else if (cpu_hit && state_current == ST_S) begin
            state_d = S_REQ;
            cmd_d   = CMD_INV;
            addr_d  = cpu_addr;
          end else if (!cpu_hit && state_current == ST_M) begin
            state_d = S_WB_REQ;
            cmd_d   = CMD_WB;
            addr_d  = victim_addr;
          end else begin
            // includes a write "hit" on an INVALID line
            state_d = S_REQ;
            cmd_d   = cpu_req_write ? CMD_WM : CMD_RM;
            addr_d  = cpu_addr;
          end
        end
      end
      S_WB_REQ: if (bus_grant) state_d = S_WB_WAIT;
      S_REQ:    if (bus_grant) state_d = S_WAIT;
      S_WB_WAIT: begin
        if (bus_ack) begin
          state_d = S_REQ;
          cmd_d   = write_q ? CMD_WM : CMD_RM;
          addr_d  = caddr_q;
        end
      end
      S_WAIT:   if (bus_ack) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`ifdef MSI_BUS_TIMEOUT_EN
    if ((state_q == S_WB_REQ || state_q == S_REQ) && bus_grant) begin
      cnt_d = '0;
    end else if ((state_q == S_WB_WAIT || state_q == S_WAIT) && !bus_ack) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == TO_LAST) begin
        error_d = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= 2'b00;
      addr_q  <= '0;
      caddr_q <= '0;
      write_q <= 1'b0;
      snext_q <= 2'b00;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      caddr_q <= caddr_d;
      write_q <= write_d;
      snext_q <= snext_d;
      error_q <= error_d;
    end
  end

`ifdef MSI_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign cpu_ready   = (state_q == S_IDLE);
  assign cpu_done    = (state_q == S_COMMIT);
  assign state_we    = (state_q == S_COMMIT);
  assign state_wdata = state_we ? snext_q : 2'b00;
  assign bus_req     = (state_q == S_WB_REQ) || (state_q == S_REQ);
  assign bus_cmd     = cmd_q;
  assign bus_addr    = addr_q;
  assign error       = error_q;

endmodule

// File: tb/tb_msi_bus_request_sequencer.sv
// Randomized bench for msi_bus_request_sequencer against a transaction-level model.
// Acts as CPU and bus arbiter; define MSI_BUS_TIMEOUT_EN to also cover the timeout.
module tb_msi_bus_request_sequencer;
  localparam int AW = 32;
`ifdef MSI_BUS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req_valid, cpu_req_write, cpu_hit;
  logic [AW-1:0] cpu_addr, victim_addr;
  logic [1:0]    state_current, state_next;
  logic          bus_grant, bus_ack;
  logic          cpu_ready, cpu_done, bus_req;
  logic [1:0]    bus_cmd;
  logic [AW-1:0] bus_addr;
  logic          state_we;
  logic [1:0]    state_wdata;
  logic          error;

  int checks   = 0;
  int failures = 0;
  logic exp_err = 1'b0;

  msi_bus_request_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_hit(cpu_hit), .cpu_addr(cpu_addr), .victim_addr(victim_addr),
    .state_current(state_current), .state_next(state_next),
    .bus_grant(bus_grant), .bus_ack(bus_ack),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done),
    .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
    .state_we(state_we), .state_wdata(state_wdata), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    cpu_req_write = 1'($urandom);
    cpu_hit       = 1'($urandom);
    cpu_addr      = $urandom;
    victim_addr   = $urandom;
    state_current = 2'($urandom);
    state_next    = 2'($urandom);
  endtask

  task automatic accept(input logic w, input logic h, input logic [1:0] cur,
                        input logic [1:0] nxt, input logic [AW-1:0] a,
                        input logic [AW-1:0] v);
    chk("ready_idle", cpu_ready, 1);
    cpu_req_valid = 1'b1;
    cpu_req_write = w;
    cpu_hit       = h;
    cpu_addr      = a;
    victim_addr   = v;
    state_current = cur;
    state_next    = nxt;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    scramble();
  endtask

  task automatic run_txn(input logic w, input logic h, input logic [1:0] cur,
                         input logic [1:0] nxt, input logic [AW-1:0] a,
                         input logic [AW-1:0] v);
    logic [1:0]    cmds[$];
    logic [AW-1:0] addrs[$];
    int n;
    accept(w, h, cur, nxt, a, v);
    if (cur == 2'b11 || nxt == 2'b11) begin
      exp_err = 1'b1;
      chk("err_set", error, 1);
      chk("err_ready", cpu_ready, 1);
      chk("err_noreq", bus_req, 0);
      chk("err_nodone", cpu_done, 0);
      return;
    end
    if (h && (!w || cur == 2'b01)) begin
    end else if (h && w && cur == 2'b10) begin
      cmds.push_back(2'b00); addrs.push_back(a);
    end else begin
      if (!h && cur == 2'b01) begin
        cmds.push_back(2'b11); addrs.push_back(v);
      end
      cmds.push_back(w ? 2'b01 : 2'b10); addrs.push_back(a);
    end
    chk("busy", cpu_ready, 0);
    if (cmds.size() == 0) chk("hit_noreq", bus_req, 0);
    foreach (cmds[i]) begin
      chk("req", bus_req, 1);
      chk("cmd", bus_cmd, cmds[i]);
      chk("addr", bus_addr, addrs[i]);
      n = $urandom_range(0, 3);
      repeat (n) begin
        bus_ack = 1'($urandom);
        @(negedge clk);
        chk("req_hold", bus_req, 1);
        chk("cmd_hold", bus_cmd, cmds[i]);
      end
      bus_ack   = 1'($urandom);
      bus_grant = 1'b1;
      @(negedge clk);
      bus_grant = 1'b0;
      bus_ack   = 1'b0;
      chk("req_drop", bus_req, 0);
      chk("no_early_done", cpu_done, 0);
      n = $urandom_range(0, 3);
      repeat (n) begin
        @(negedge clk);
        chk("wait_noreq", bus_req, 0);
      end
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
    end
    chk("done", cpu_done, 1);
    chk("we", state_we, 1);
    chk("wdata", state_wdata, nxt);
    chk("err_sticky", error, exp_err);
    chk("busy_commit", cpu_ready, 0);
    @(negedge clk);
    chk("done_pulse", cpu_done, 0);
    chk("we_pulse", state_we, 0);
    chk("ready_back", cpu_ready, 1);
  endtask

  task automatic rand_txn();
    logic h;
    logic [1:0] cur, nxt;
    h   = 1'($urandom);
    cur = h ? ($urandom_range(0, 1) ? 2'b01 : 2'b10) : 2'($urandom_range(0, 2));
    if ($urandom_range(0, 11) == 0) cur = 2'b11;
    nxt = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    run_txn(1'($urandom), h, cur, nxt, $urandom, $urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req_valid = 1'b0;
    bus_grant = 1'b0;
    bus_ack = 1'b0;
    scramble();
    #12;
    chk("rst_ready", cpu_ready, 1);
    chk("rst_done", cpu_done, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_cmd", bus_cmd, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_we", state_we, 0);
    chk("rst_wdata", state_wdata, 0);
    chk("rst_err", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 1'b1, 2'b10, 2'b10, 32'h1000, 32'h2000);
    run_txn(1'b1, 1'b1, 2'b10, 2'b01, 32'h1234, 32'h0);
    run_txn(1'b0, 1'b0, 2'b01, 2'b10, 32'h80, 32'h40);
    run_txn(1'b1, 1'b1, 2'b01, 2'b01, 32'h55, 32'h66);
    run_txn(1'b0, 1'b1, 2'b10, 2'b11, 32'h10, 32'h20);
    @(negedge clk);
    chk("err_stays", error, 1);
    run_txn(1'b1, 1'b0, 2'b00, 2'b01, 32'h300, 32'h400);

    repeat (60) rand_txn();

    accept(1'b0, 1'b0, 2'b10, 2'b10, 32'hABC, 32'h0);
    bus_grant = 1'b1;
    @(negedge clk);
    bus_grant = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    chk("arst_ready", cpu_ready, 1);
    chk("arst_req", bus_req, 0);
    chk("arst_we", state_we, 0);
    chk("arst_addr", bus_addr, 0);
    chk("arst_err", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("arst_no_we", state_we, 0);
    chk("arst_idle", cpu_ready, 1);
    run_txn(1'b1, 1'b0, 2'b01, 2'b01, 32'h900, 32'h800);

`ifdef MSI_BUS_TIMEOUT_EN
    accept(1'b0, 1'b0, 2'b00, 2'b10, 32'h77, 32'h0);
    bus_grant = 1'b1;
    @(negedge clk);
    bus_grant = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("to_waiting", cpu_ready, 0);
      chk("to_no_err", error, 0);
    end
    @(negedge clk);
    chk("to_idle", cpu_ready, 1);
    chk("to_err", error, 1);
    chk("to_nodone", cpu_done, 0);
    chk("to_nowe", state_we, 0);
    exp_err = 1'b1;
    run_txn(1'b0, 1'b1, 2'b01, 2'b01, 32'h5, 32'h6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/msi_bus_request_sequencer.md
Name: msi_bus_request_sequencer

Overview:
Sequential stage directly downstream of the MSI CPU-request next-state logic. It takes one CPU access together with the line's current and next MSI state, and issues the required snoopy-bus transactions through a request/grant/ack handshake. This includes a write-back of a MODIFIED victim before a miss. After the bus work completes, it commits the next state to the cache state array. It stalls the CPU from request acceptance until commit.

Parameters:
ADDR_WIDTH, 32, width of block addresses on CPU and bus side
TIMEOUT_CYCLES, 255, max cycles waiting for bus_ack (used only with MSI_BUS_TIMEOUT_EN); counter width is clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
cpu_req_valid  input  1  CPU access present; sampled only when cpu_ready=1
cpu_req_write  input  1  1=write, 0=read
cpu_hit  input  1  tag match for cpu_addr
cpu_addr  input  ADDR_WIDTH  block address of access
victim_addr  input  ADDR_WIDTH  block address of line being replaced on miss
state_current  input  2  line state: INVALID=00, MODIFIED=01, SHARED=10
state_next  input  2  next state from controller; 11 = error code
bus_grant  input  1  arbiter grant for pending bus_req
bus_ack  input  1  one-cycle pulse: granted transaction complete
cpu_ready  output  1  high only in IDLE
cpu_done  output  1  one-cycle pulse when access completes
bus_req  output  1  bus request
bus_cmd  output  2  INVALIDATE=00, WRITE_MISS=01, READ_MISS=10, WRITE_BACK=11
bus_addr  output  ADDR_WIDTH  address for bus_cmd
state_we  output  1  one-cycle write strobe to state array
state_wdata  output  2  state written with state_we
error  output  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; cpu_ready=1; cpu_done=0; bus_req=0; bus_cmd=00; bus_addr=0; state_we=0; state_wdata=00; error=0; timeout counter=0.
- States: IDLE, WB_REQ, WB_WAIT, REQ, WAIT, COMMIT.
- IDLE accept: the cycle with cpu_req_valid=1 and cpu_ready=1. At accept, latch write, hit, cpu_addr, victim_addr, state_current and state_next.
- Accept decision, first matching rule:
  - state_next=11 or state_current=11: set error; stay IDLE; no cpu_done.
  - Read hit, or write hit with current=MODIFIED: go to COMMIT (no bus).
  - Write hit with current=SHARED: go to REQ with cmd=INVALIDATE, addr=cpu_addr.
  - Miss with current=MODIFIED: go to WB_REQ with cmd=WRITE_BACK, addr=victim_addr.
  - Miss otherwise: go to REQ with cmd=WRITE_MISS (write) or READ_MISS (read), addr=cpu_addr.
- WB_REQ / REQ:
  - bus_req=1; bus_cmd and bus_addr stable until grant.
  - On bus_grant=1: drop bus_req next cycle; go to WB_WAIT / WAIT.
- WB_WAIT: on bus_ack, go to REQ with the miss command (write→WRITE_MISS, read→READ_MISS), addr=cpu_addr.
- WAIT: on bus_ack, go to COMMIT.
- bus_ack outside WB_WAIT/WAIT is ignored.
- COMMIT (exactly 1 cycle): state_we=1, state_wdata=latched state_next, cpu_done=1; next state IDLE.
- cpu_ready=0 from the cycle after accept through COMMIT; cpu_ready=1 again on the cycle after COMMIT.
- Latency:
  - Hit with no bus: cpu_done 1 cycle after accept.
  - Bus path: grant cycle + ack cycle + 1.
- Simultaneous bus_grant and bus_ack in the same cycle: grant is taken; the ack is ignored. The arbiter must not do this.
- Inputs changing after accept have no effect (latched values used).
- error clears only on reset.
- Reset mid-transaction: immediate return to reset values; the in-flight transaction is abandoned; no state_we.

Optional Feature:
MSI_BUS_TIMEOUT_EN:
- Defined: in WB_WAIT/WAIT, a counter increments each cycle without bus_ack. If it reaches TIMEOUT_CYCLES: set error; go to IDLE; no state_we; no cpu_done. The counter clears on entry to each wait state.
- Undefined: no counter; the FSM waits forever for bus_ack.

Test Plan:
- Read hit, current=SHARED, next=SHARED → no bus_req; cpu_done and state_we (wdata=10) 1 cycle after accept.
- Write hit, current=SHARED, next=MODIFIED, grant after 2 cycles, ack 3 cycles later → bus_cmd=00 at cpu_addr; COMMIT with wdata=01.
- Read miss, current=MODIFIED, victim=0x40, addr=0x80 → WRITE_BACK@0x40, then READ_MISS@0x80; commit wdata=10; exactly 2 grant/ack pairs.
- state_next=11 at accept → error=1 and stays 1; no bus_req; cpu_ready stays 1; the next valid request is processed normally.
- rst_n low during WAIT → outputs return to reset values asynchronously; no state_we.
- With MSI_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack after grant → error=1 after 4 wait cycles; return to IDLE with no cpu_done.
